// File: rtl/instr_fetch_ctrl_if.sv
// Instruction-bus and fetch-queue-push signal bundle for instr_fetch_ctrl.
// The master modport is the fetch controller side.
// The slave modport is the bus and queue side.
interface instr_fetch_ctrl_if;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic        q_in_req;
  logic        q_in_16bit;
  logic [31:0] q_in;
  logic        q_clr;
  logic [1:0]  q_vacant;

  modport master (
    output ibus_req, ibus_addr, q_in_req, q_in_16bit, q_in, q_clr,
    input  ibus_ack, ibus_rdata, q_vacant
  );

  modport slave (
    input  ibus_req, ibus_addr, q_in_req, q_in_16bit, q_in, q_clr,
    output ibus_ack, ibus_rdata, q_vacant
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: upstream stage of the instruction fetch queue.
// - Holds the fetch PC and issues one word read at a time on the instruction bus.
// - Pushes the returned word into the queue, or only its upper halfword when the PC
//   points at the odd halfword.
// - A redirect clears the queue and reloads the PC. A read that is still in flight
//   is completed on the bus and its data is dropped.
// Optional build macro IFETCH_STALL_CNT_EN adds a saturating stall_cnt output.
// stall_cnt counts bus cycles that are waiting for an ack.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  instr_fetch_ctrl_if.master bus,
  output logic [31:0] fetch_pc
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] addr_q;
  logic        req_q;
  logic        push;
  logic        space;
  logic        unused_pc_bit0;

  // Redirect targets are halfword aligned, so bit 0 of redirect_pc is dropped.
  assign unused_pc_bit0 = redirect_pc[0];

  // An odd-halfword PC needs one slot; a word fetch needs two slots.
  assign space = pc[1] ? (bus.q_vacant >= 2'd1) : (bus.q_vacant == 2'd2);

  // Next-state, next-PC and push decode.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_en && !redirect && space) state_nxt = REQ;
      end
      REQ: begin
        if (bus.ibus_ack) begin
          state_nxt = IDLE;
          if (!redirect) begin
            push   = 1'b1;
            pc_nxt = pc + (pc[1] ? 32'd2 : 32'd4);
          end
        end else if (redirect) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.ibus_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A redirect always wins over the sequential increment.
    if (redirect) pc_nxt = {redirect_pc[31:1], 1'b0};
  end

  // State, PC and registered bus request/address.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      addr_q <= {RESET_PC[31:2], 2'b00};
      req_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      req_q <= (state_nxt != IDLE);
      // The address is latched only at issue, so DISCARD keeps the old address.
      if (state == IDLE && state_nxt == REQ) addr_q <= {pc[31:2], 2'b00};
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  // Count the cycles a read waits on the bus, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt <= 32'd0;
    end else if (state != IDLE && !bus.ibus_ack && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  assign bus.ibus_req   = req_q;
  assign bus.ibus_addr  = addr_q;
  assign bus.q_in_req   = push;
  assign bus.q_in_16bit = push & pc[1];
  assign bus.q_in       = pc[1] ? {16'h0000, bus.ibus_rdata[31:16]} : bus.ibus_rdata;
  assign bus.q_clr      = redirect;
  assign fetch_pc       = pc;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl.
// A transaction-level reference model tracks the expected PC and the read in flight.
// It also predicts the queue push expected for each bus acknowledge.
// The bus responder lives in the per-cycle step task and acks after a randomized wait.
module tb_instr_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] fetch_pc;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  instr_fetch_ctrl_if bus();

  instr_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fetch_en   (fetch_en),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .bus        (bus.master),
    .fetch_pc   (fetch_pc)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_rd_pc;
  bit          m_busy;
  bit          m_killed;
  int          m_wait;
  int          m_lat;
  int          m_stall;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          fix_data = 1'b0;
  logic [31:0] fix_val = 32'h0;
  logic [31:0] issue_log[$];
  logic [32:0] push_log[$];
  int          checks = 0;
  int          errors = 0;

  task automatic model_reset();
    m_pc = RESET_PC; m_busy = 0; m_killed = 0; m_wait = 0; m_stall = 0;
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic step();
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] exp_q;
    bit          exp_push;
    bit          space;
    checks++;
    if (bus.ibus_req !== m_busy) begin
      errors++; $display("FAIL ibus_req at %0t: got %b want %b", $time, bus.ibus_req, m_busy);
    end
    checks++;
    if (fetch_pc !== m_pc) begin
      errors++; $display("FAIL fetch_pc at %0t: got %h want %h", $time, fetch_pc, m_pc);
    end
    if (m_busy) begin
      checks++;
      if (bus.ibus_addr !== {m_rd_pc[31:2], 2'b00}) begin
        errors++; $display("FAIL ibus_addr at %0t: got %h want %h", $time, bus.ibus_addr, {m_rd_pc[31:2], 2'b00});
      end
      if (m_wait == 0) issue_log.push_back(bus.ibus_addr);
    end
    ack   = m_busy && (m_wait >= m_lat);
    rdata = fix_data ? fix_val : $urandom;
    bus.ibus_ack   = ack;
    bus.ibus_rdata = rdata;
    #1;
    exp_push = ack && !m_killed && !redirect;
    checks++;
    if (bus.q_clr !== redirect) begin
      errors++; $display("FAIL q_clr at %0t: got %b want %b", $time, bus.q_clr, redirect);
    end
    checks++;
    if (bus.q_in_req !== exp_push) begin
      errors++; $display("FAIL q_in_req at %0t: got %b want %b", $time, bus.q_in_req, exp_push);
    end
    if (exp_push) begin
      exp_q = m_rd_pc[1] ? {16'h0000, rdata[31:16]} : rdata;
      checks++;
      if (bus.q_in_16bit !== m_rd_pc[1] || bus.q_in !== exp_q) begin
        errors++; $display("FAIL push_data at %0t: got %b/%h want %b/%h", $time, bus.q_in_16bit, bus.q_in, m_rd_pc[1], exp_q);
      end
    end
    if (bus.q_in_req === 1'b1) push_log.push_back({bus.q_in_16bit, bus.q_in});
    space = m_pc[1] ? (bus.q_vacant >= 2'd1) : (bus.q_vacant == 2'd2);
    if (m_busy) begin
      if (ack) begin
        m_busy = 0;
        if (exp_push) m_pc = m_rd_pc + (m_rd_pc[1] ? 32'd2 : 32'd4);
      end else begin
        m_wait++;
        m_stall++;
        if (redirect) m_killed = 1;
      end
    end else if (fetch_en && !redirect && space) begin
      m_busy = 1; m_rd_pc = m_pc; m_wait = 0; m_killed = 0;
      m_lat = $urandom_range(lat_max, lat_min);
    end
    if (redirect) m_pc = {redirect_pc[31:1], 1'b0};
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    fetch_en = 0; redirect = 0;
    while (m_busy && n < 40) begin step(); n++; end
    checks++;
    if (m_busy) begin errors++; $display("FAIL drain_timeout: still busy after %0d cycles, want idle", n); end
  endtask

  task automatic jump(input logic [31:0] pc);
    fetch_en = 0; redirect = 1; redirect_pc = pc;
    step();
    redirect = 0;
  endtask

  task automatic test_reset();
    rstn = 0; fetch_en = 1; bus.q_vacant = 2; bus.ibus_ack = 0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (bus.ibus_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.ibus_req); end
    checks++;
    if (bus.q_in_req !== 1'b0) begin errors++; $display("FAIL reset_push: got %b want 0", bus.q_in_req); end
    checks++;
    if (fetch_pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", fetch_pc, RESET_PC); end
    checks++;
    if (bus.q_clr !== 1'b0) begin errors++; $display("FAIL reset_qclr: got %b want 0", bus.q_clr); end
    redirect = 1; #1;
    checks++;
    if (bus.q_clr !== 1'b1) begin errors++; $display("FAIL qclr_comb: got %b want 1", bus.q_clr); end
    redirect = 0;
`ifdef IFETCH_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
`endif
    @(negedge clk);
    rstn = 1; fetch_en = 0;
    model_reset();
  endtask

  task automatic test_sequential();
    int i0 = issue_log.size();
    int p0 = push_log.size();
    int cyc = 0;
    lat_min = 1; lat_max = 1; fetch_en = 1; bus.q_vacant = 2;
    while (push_log.size() < p0 + 3 && cyc < 40) begin step(); cyc++; end
    fetch_en = 0;
    checks++;
    if (cyc != 9) begin errors++; $display("FAIL seq_cycles: got %0d want 9", cyc); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (issue_log.size() < i0 + 3 || issue_log[i0+k] !== 32'(k * 4)) begin
        errors++; $display("FAIL seq_addr%0d: got %h want %h", k, (issue_log.size() > i0 + k) ? issue_log[i0+k] : 32'hx, 32'(k * 4));
      end
      checks++;
      if (push_log.size() < p0 + 3 || push_log[p0+k][32] !== 1'b0) begin
        errors++; $display("FAIL seq_width%0d: push not 32-bit or missing", k);
      end
    end
    drain();
  endtask

  task automatic test_odd_redirect();
    int i0, p0, n;
    fix_data = 1; fix_val = 32'hAAAA_BBBB; lat_min = 1; lat_max = 1; bus.q_vacant = 2;
    jump(32'h0000_0102);
    i0 = issue_log.size(); p0 = push_log.size(); n = 0;
    fetch_en = 1;
    while (push_log.size() < p0 + 2 && n < 40) begin step(); n++; end
    fetch_en = 0;
    checks++;
    if (issue_log.size() < i0 + 2 || issue_log[i0] !== 32'h100 || issue_log[i0+1] !== 32'h104) begin
      errors++; $display("FAIL odd_addr: got %0d reads, want 0x100 then 0x104", issue_log.size() - i0);
    end
    checks++;
    if (push_log.size() < p0 + 2 || push_log[p0] !== {1'b1, 32'h0000_AAAA}) begin
      errors++; $display("FAIL odd_push16: got %h want %h", (push_log.size() > p0) ? push_log[p0] : 33'hx, {1'b1, 32'h0000_AAAA});
    end
    checks++;
    if (push_log.size() < p0 + 2 || push_log[p0+1] !== {1'b0, 32'hAAAA_BBBB}) begin
      errors++; $display("FAIL odd_push32: got %h want %h", (push_log.size() > p0 + 1) ? push_log[p0+1] : 33'hx, {1'b0, 32'hAAAA_BBBB});
    end
    drain();
    fix_data = 0;
  endtask

  task automatic test_space();
    int i0;
    jump(32'h0000_0010);
    i0 = issue_log.size();
    fetch_en = 1; bus.q_vacant = 1;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (bus.ibus_req !== 1'b0 || issue_log.size() != i0) begin
      errors++; $display("FAIL space_hold: got req=%b want 0", bus.ibus_req);
    end
    bus.q_vacant = 2;
    step();
    checks++;
    if (bus.ibus_req !== 1'b1) begin errors++; $display("FAIL space_issue: got req=%b want 1", bus.ibus_req); end
    drain();
  endtask

  task automatic test_redirect_in_req();
    int i0, p0, n;
    jump(32'h0000_0040);
    lat_min = 3; lat_max = 3; bus.q_vacant = 2; fetch_en = 1;
    i0 = issue_log.size(); p0 = push_log.size();
    step();
    redirect = 1; redirect_pc = 32'h0000_0200;
    step();
    redirect = 0; n = 0;
    while (issue_log.size() < i0 + 2 && n < 40) begin step(); n++; end
    fetch_en = 0;
    checks++;
    if (issue_log.size() < i0 + 2 || issue_log[i0] !== 32'h40 || issue_log[i0+1] !== 32'h200) begin
      errors++; $display("FAIL rdr_req_addr: got %0d reads, want 0x40 then 0x200", issue_log.size() - i0);
    end
    checks++;
    if (push_log.size() != p0) begin
      errors++; $display("FAIL rdr_req_push: got %0d pushes want 0", push_log.size() - p0);
    end
    drain();
  endtask

  task automatic test_redirect_ack();
    int i0, p0, n;
    jump(32'h0000_0080);
    lat_min = 2; lat_max = 2; bus.q_vacant = 2; fetch_en = 1;
    i0 = issue_log.size(); p0 = push_log.size();
    step(); step(); step();
    redirect = 1; redirect_pc = 32'h0000_0300;
    step();
    redirect = 0; n = 0;
    checks++;
    if (push_log.size() != p0) begin
      errors++; $display("FAIL rdr_ack_push: got %0d pushes want 0", push_log.size() - p0);
    end
    while (issue_log.size() < i0 + 2 && n < 40) begin step(); n++; end
    fetch_en = 0;
    checks++;
    if (issue_log.size() < i0 + 2 || issue_log[i0+1] !== 32'h300) begin
      errors++; $display("FAIL rdr_ack_addr: got %0d reads, want next at 0x300", issue_log.size() - i0);
    end
    drain();
  endtask

  task automatic test_fetch_en_off();
    int i0, p0;
    jump(32'h0000_0500);
    lat_min = 3; lat_max = 3; bus.q_vacant = 2; fetch_en = 1;
    i0 = issue_log.size(); p0 = push_log.size();
    step();
    fetch_en = 0;
    for (int k = 0; k < 15; k++) step();
    checks++;
    if (issue_log.size() != i0 + 1 || push_log.size() != p0 + 1) begin
      errors++; $display("FAIL fe_off: got %0d reads %0d pushes want 1 1", issue_log.size() - i0, push_log.size() - p0);
    end
  endtask

  task automatic test_wrap();
    int p0, n;
    lat_min = 0; lat_max = 0; bus.q_vacant = 2;
    for (int w = 0; w < 2; w++) begin
      jump(w == 0 ? 32'hFFFF_FFFC : 32'hFFFF_FFFE);
      p0 = push_log.size(); n = 0; fetch_en = 1;
      while (push_log.size() < p0 + 1 && n < 20) begin step(); n++; end
      fetch_en = 0;
      step();
      checks++;
      if (fetch_pc !== 32'h0) begin errors++; $display("FAIL wrap%0d: got %h want 00000000", w, fetch_pc); end
      checks++;
      if (push_log.size() < p0 + 1 || push_log[p0][32] !== 1'(w)) begin
        errors++; $display("FAIL wrap_width%0d: push missing or wrong width, want 16bit=%0d", w, w);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int i0, n;
    jump(32'h0000_0600);
    lat_min = 4; lat_max = 4; bus.q_vacant = 2; fetch_en = 1;
    step(); step();
    rstn = 0; fetch_en = 0; bus.ibus_ack = 0;
    @(negedge clk);
    checks++;
    if (bus.ibus_req !== 1'b0 || fetch_pc !== RESET_PC) begin
      errors++; $display("FAIL rst_mid: got req=%b pc=%h want 0 %h", bus.ibus_req, fetch_pc, RESET_PC);
    end
    rstn = 1; model_reset();
    lat_min = 1; lat_max = 1; fetch_en = 1;
    i0 = issue_log.size(); n = 0;
    while (issue_log.size() < i0 + 1 && n < 20) begin step(); n++; end
    checks++;
    if (issue_log.size() < i0 + 1 || issue_log[i0] !== {RESET_PC[31:2], 2'b00}) begin
      errors++; $display("FAIL rst_mid_addr: no read at reset PC %h", RESET_PC);
    end
    drain();
  endtask

`ifdef IFETCH_STALL_CNT_EN
  task automatic test_stall_cnt();
    int i0, n;
    rstn = 0; fetch_en = 0; bus.ibus_ack = 0;
    @(negedge clk);
    rstn = 1; model_reset();
    lat_min = 3; lat_max = 3; bus.q_vacant = 2; fetch_en = 1;
    i0 = issue_log.size(); n = 0;
    while (issue_log.size() < i0 + 2 && n < 40) begin step(); n++; end
    drain();
    checks++;
    if (stall_cnt !== 32'd6) begin errors++; $display("FAIL stall_cnt: got %0d want 6", stall_cnt); end
  endtask
`endif

  task automatic test_random();
    int p0 = push_log.size();
    for (int k = 0; k < 3000; k++) begin
      lat_min = 0; lat_max = 4;
      fetch_en     = ($urandom_range(9, 0) != 0);
      redirect     = ($urandom_range(19, 0) == 0);
      redirect_pc  = $urandom;
      bus.q_vacant = 2'($urandom_range(2, 0));
      step();
    end
    drain();
    checks++;
    if (push_log.size() - p0 < 100) begin
      errors++; $display("FAIL rand_progress: got %0d pushes want >=100", push_log.size() - p0);
    end
`ifdef IFETCH_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'(m_stall)) begin errors++; $display("FAIL rand_stall: got %0d want %0d", stall_cnt, m_stall); end
`endif
  endtask

  initial begin
    bus.ibus_ack = 0; bus.ibus_rdata = 0; bus.q_vacant = 2;
    model_reset();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_odd_redirect();
    test_space();
    test_redirect_in_req();
    test_redirect_ack();
    test_fetch_en_off();
    test_wrap();
    test_reset_mid_read();
`ifdef IFETCH_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
